// File: rtl/csr_seq_ctrl.sv
// Sequences one CSR request (CSRRx / ECALL / MRET) onto the single-port CSR file; response after 1 (illegal), 2 (CSRRx), 3 (MRET) or 5 (ECALL) cycles.
// Backpressure: req_ready_o only in IDLE; the response is held stable in RESP until resp_ready_i.
module csr_seq_ctrl #(
    parameter int               XLEN        = 64,
    parameter logic [XLEN-1:0]  ECALL_CAUSE = XLEN'(11)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [2:0]          req_op_i,
    input  logic [11:0]         req_addr_i,
    input  logic [XLEN-1:0]     req_src_i,
    input  logic                req_src_zero_i,
    input  logic [XLEN-1:0]     req_pc_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [XLEN-1:0]     resp_rdata_o,
    output logic                resp_redirect_o,
    output logic [XLEN-1:0]     resp_target_o,
    output logic                resp_illegal_o,
    output logic [11:0]         csr_addr_o,
    output logic                csr_re_o,
    output logic                csr_we_o,
    output logic [XLEN-1:0]     csr_wdata_o,
    input  logic [XLEN-1:0]     csr_rdata_i
);

    localparam logic [2:0] OP_RW    = 3'b001;
    localparam logic [2:0] OP_RS    = 3'b010;
    localparam logic [2:0] OP_RC    = 3'b011;
    localparam logic [2:0] OP_ECALL = 3'b100;
    localparam logic [2:0] OP_MRET  = 3'b101;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    typedef struct packed {
        logic [2:0]      op;
        logic [11:0]     addr;
        logic [XLEN-1:0] src;
        logic            src_zero;
        logic [XLEN-1:0] pc;
    } req_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACC,
        S_T_EPC,
        S_T_CAUSE,
        S_T_STAT,
        S_T_VEC,
        S_R_EPC,
        S_R_STAT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    req_t            req_q, req_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            redirect_q, redirect_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] status_w;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            rdata_q    <= '0;
            target_q   <= '0;
            redirect_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rdata_q    <= rdata_d;
            target_q   <= target_d;
            redirect_q <= redirect_d;
            illegal_q  <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        target_d    = target_q;
        redirect_d  = redirect_q;
        illegal_d   = illegal_q;
        csr_addr_o  = '0;
        csr_re_o    = 1'b0;
        csr_we_o    = 1'b0;
        csr_wdata_o = '0;
        status_w    = csr_rdata_i;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    req_d.op       = req_op_i;
                    req_d.addr     = req_addr_i;
                    req_d.src      = req_src_i;
                    req_d.src_zero = req_src_zero_i;
                    req_d.pc       = req_pc_i;
                    rdata_d        = '0;
                    target_d       = '0;
                    redirect_d     = 1'b0;
                    illegal_d      = 1'b0;
                    case (req_op_i)
                        OP_RW, OP_RS, OP_RC: state_d = S_ACC;
                        OP_ECALL: begin
                            state_d    = S_T_EPC;
                            redirect_d = 1'b1;
                        end
                        OP_MRET: begin
                            state_d    = S_R_EPC;
                            redirect_d = 1'b1;
                        end
                        default: begin
                            state_d   = S_RESP;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            S_ACC: begin
                // Read-modify-write uses this cycle's read data combinationally.
                csr_re_o   = 1'b1;
                csr_addr_o = req_q.addr;
                rdata_d    = csr_rdata_i;
                case (req_q.op)
                    OP_RW: begin
                        csr_we_o    = 1'b1;
                        csr_wdata_o = req_q.src;
                    end
                    OP_RS: begin
                        csr_we_o    = !req_q.src_zero;
                        csr_wdata_o = csr_rdata_i | req_q.src;
                    end
                    default: begin
                        csr_we_o    = !req_q.src_zero;
                        csr_wdata_o = csr_rdata_i & ~req_q.src;
                    end
                endcase
                state_d = S_RESP;
            end
            S_T_EPC: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = A_MEPC;
                csr_wdata_o = req_q.pc;
                state_d     = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = A_MCAUSE;
                csr_wdata_o = ECALL_CAUSE;
                state_d     = S_T_STAT;
            end
            S_T_STAT: begin
                status_w[7]     = csr_rdata_i[3];
                status_w[3]     = 1'b0;
                status_w[12:11] = 2'b11;
                csr_re_o        = 1'b1;
                csr_we_o        = 1'b1;
                csr_addr_o      = A_MSTATUS;
                csr_wdata_o     = status_w;
                state_d         = S_T_VEC;
            end
            S_T_VEC: begin
                // Direct mode only: vector mode bits are dropped.
                csr_re_o   = 1'b1;
                csr_addr_o = A_MTVEC;
                target_d   = {csr_rdata_i[XLEN-1:2], 2'b00};
                state_d    = S_RESP;
            end
            S_R_EPC: begin
                csr_re_o   = 1'b1;
                csr_addr_o = A_MEPC;
                target_d   = csr_rdata_i;
                state_d    = S_R_STAT;
            end
            S_R_STAT: begin
                status_w[3]     = csr_rdata_i[7];
                status_w[7]     = 1'b1;
                status_w[12:11] = 2'b00;
                csr_re_o        = 1'b1;
                csr_we_o        = 1'b1;
                csr_addr_o      = A_MSTATUS;
                csr_wdata_o     = status_w;
                state_d         = S_RESP;
            end
            S_RESP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign resp_valid_o    = (state_q == S_RESP);
    assign resp_rdata_o    = rdata_q;
    assign resp_target_o   = target_q;
    assign resp_redirect_o = redirect_q;
    assign resp_illegal_o  = illegal_q;

endmodule
